lpc_stream_sink_ram: RTL
========================

Name: lpc_stream_sink_ram

Overview:
- Parametrised single-clock successor to the Qsys sink RAM.
- Captures a frame of samples from an Avalon-ST sink into on-chip RAM under an arm/capture/done state machine.
- Exposes the buffer to a host through an Avalon-MM slave with byte enables and configurable read latency.
- Sits between the LPC filter output stream and the Nios/HPS readback path.

Parameters:
DATA_WIDTH, 16, sample and word width in bits; multiple of 8.
ADDR_WIDTH, 13, word address width; depth = 2**ADDR_WIDTH.
READ_LATENCY, 1, MM read latency in cycles; legal values 1 or 2 (2 adds an output register).

Ports:
clk  in  1  single system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_WIDTH  MM word address
byteenable  in  DATA_WIDTH/8  MM write byte lanes
chipselect  in  1  MM select
read  in  1  MM read strobe (qualified by chipselect)
write  in  1  MM write strobe (qualified by chipselect)
writedata  in  DATA_WIDTH  MM write data
readdata  out  DATA_WIDTH  MM read data
readdatavalid  out  1  readdata valid, READ_LATENCY cycles after accepted read
st_data  in  DATA_WIDTH  sample data
st_valid  in  1  sample valid
st_ready  out  1  sink ready
arm  in  1  one-cycle pulse: start a capture
capture_len  in  ADDR_WIDTH+1  samples to capture, 1..2**ADDR_WIDTH
busy  out  1  capture in progress
done  out  1  frame complete, sticky until next arm
wr_ptr  out  ADDR_WIDTH+1  samples written in current/last frame
mm_wr_err  out  1  sticky: MM write dropped during capture

Behaviour:
- Reset values: readdata=0, readdatavalid=0, st_ready=0, busy=0, done=0, wr_ptr=0, mm_wr_err=0, state IDLE. RAM contents are not cleared.
- States:
  - IDLE: st_ready=0. arm -> CAPTURE; wr_ptr<=0, done<=0, mm_wr_err<=0, len latched.
  - CAPTURE: busy=1, st_ready=1. Each st_valid&st_ready writes st_data to RAM[wr_ptr], all bytes, and wr_ptr increments. The beat that makes wr_ptr==len -> DONE.
  - DONE: busy=0, done=1, st_ready=0. arm -> CAPTURE, as from IDLE.
- capture_len=0 is treated as 2**ADDR_WIDTH (full buffer). Values above 2**ADDR_WIDTH saturate to 2**ADDR_WIDTH. No wrap: capture stops at len.
- arm while in CAPTURE restarts the frame: wr_ptr<=0, done stays 0. The beat accepted on the arm cycle is discarded.
- Single write port arbitration:
  - In CAPTURE, the stream owns the write port. Any MM write is dropped and sets mm_wr_err.
  - In IDLE/DONE, MM writes commit with byteenable masking; only enabled lanes change.
- MM reads are allowed in every state.
  - Accepted read in cycle N -> readdatavalid high in cycle N+READ_LATENCY for exactly one cycle.
  - Back-to-back reads are fully pipelined, one per cycle.
- Read-during-write to the same address (MM or stream) in the same cycle returns the new data, merged per byte for MM writes.
- chipselect with read&write both high: the write is performed, the read is ignored and produces no readdatavalid.
- Reset asserted mid-capture aborts to IDLE with all flags cleared. In-flight readdatavalid is cancelled.

Test Plan:
- Reset, then arm with capture_len=4, stream 0x1111,0x2222,0x3333,0x4444 with st_valid gaps -> done=1 after the 4th beat, wr_ptr=4, st_ready=0. MM reads of addr 0..3 return the samples, readdatavalid exactly READ_LATENCY cycles after each read (run with READ_LATENCY=1 and 2).
- In IDLE, MM write 0xABCD to addr 5 with byteenable=2'b01 over prior 0x1234 -> read returns 0x12CD.
- During CAPTURE, MM write to addr 0 -> write dropped, mm_wr_err=1. RAM[0] keeps the stream sample. Next arm clears mm_wr_err.
- capture_len=0 with ADDR_WIDTH=4 -> captures 16 samples, wr_ptr=16, the 17th st_valid sees st_ready=0.
- Re-arm mid-frame after 2 beats -> wr_ptr resets to 0, the next sample lands at addr 0, done only after the full new len.
- Assert reset_n low after 3 beats of an 8-beat capture and during a pending read -> all outputs return to reset values immediately, no readdatavalid emitted. A new arm then works normally.

Source files
------------

// File: rtl/lpc_stream_sink_ram.sv
// Frame-capture sink RAM: an Avalon-ST stream fills the buffer under arm/capture/done control,
// and an Avalon-MM slave reads/writes it with byte enables and 1- or 2-cycle read latency.

// One byte lane of the buffer; a write to the address being read returns the new byte.
module lpc_stream_sink_ram_lane #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

module lpc_stream_sink_ram #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 13,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic                    arm,
  input  logic [ADDR_WIDTH:0]     capture_len,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     wr_ptr,
  output logic                    mm_wr_err
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE_S} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH:0] len, len_eff;
  logic mm_wr, mm_rd, beat, capturing;

  assign capturing = (state == CAPTURE);
  assign mm_wr     = chipselect & write;
  assign mm_rd     = chipselect & read & ~write;
  // Beat presented on an arm cycle belongs to the abandoned frame.
  assign beat      = capturing & st_valid & ~arm;
  assign len_eff   = (capture_len == '0 || capture_len > DEPTH) ? DEPTH : capture_len;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    st_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      CAPTURE: begin
        busy     = 1'b1;
        st_ready = 1'b1;
      end
      DONE_S:  done = 1'b1;
      default: ;
    endcase
    if (arm)
      state_nxt = CAPTURE;
    else if (beat && (wr_ptr + 1'b1) == len)
      state_nxt = DONE_S;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      len       <= '0;
      mm_wr_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (arm) begin
        wr_ptr    <= '0;
        len       <= len_eff;
        mm_wr_err <= 1'b0;
      end else begin
        if (beat) wr_ptr <= wr_ptr + 1'b1;
        if (capturing && mm_wr) mm_wr_err <= 1'b1;
      end
    end

  // Single write port: stream owns it during capture, MM otherwise.
  logic [NUM_LANES-1:0]        we_l;
  logic [NUM_LANES-1:0][7:0]   wdata_l, rdata_l;
  logic [ADDR_WIDTH-1:0]       waddr;
  logic [DATA_WIDTH-1:0]       rd_word;

  assign waddr   = capturing ? wr_ptr[ADDR_WIDTH-1:0] : address;
  assign wdata_l = capturing ? st_data : writedata;
  assign we_l    = capturing ? {NUM_LANES{beat}} : ({NUM_LANES{mm_wr}} & byteenable);
  assign rd_word = rdata_l;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lpc_stream_sink_ram_lane #(.AW(ADDR_WIDTH)) u_lane (
      .clk   (clk),
      .we    (we_l[i]),
      .waddr (waddr),
      .wdata (wdata_l[i]),
      .raddr (address),
      .rdata (rdata_l[i])
    );
  end

  logic [READ_LATENCY:1]                 vld_pipe;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] rd_pipe;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld_pipe[1] <= 1'b0;
      rd_pipe[1]  <= '0;
    end else begin
      vld_pipe[1] <= mm_rd;
      if (mm_rd) rd_pipe[1] <= rd_word;
    end

  for (genvar s = 2; s <= READ_LATENCY; s++) begin : g_rd_stage
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        vld_pipe[s] <= 1'b0;
        rd_pipe[s]  <= '0;
      end else begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) rd_pipe[s] <= rd_pipe[s-1];
      end
  end

  assign readdata      = rd_pipe[READ_LATENCY];
  assign readdatavalid = vld_pipe[READ_LATENCY];
endmodule
